// File: rtl/bnat_counter.sv
// Up/down natural-binary counter, range 0..MAX, prescaled step, clamped parallel load.
// Latency: bnat/step/tc are registered and reflect a load or step one edge after it.
// Backpressure: none; en stalls count and prescaler, load always takes effect.
module bnat_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bnat,
    output logic             step,
    output logic             tc
);

    localparam int               PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PTOP = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic [PW-1:0]    pre;
    logic             pre_top;
    logic             step_cyc;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_wrap;

    assign pre_top  = (pre == PTOP);
    assign step_cyc = en && pre_top;

    always_comb begin
        load_clamped = load_val;
        if (load_val > MAXV) begin
            load_clamped = MAXV;
        end
    end

    // Wrap is decided by comparing before the arithmetic, so neither the
    // increment past MAX nor the decrement below 0 is ever applied.
    always_comb begin
        cnt_next = bnat;
        cnt_wrap = 1'b0;
        if (up) begin
            if (bnat == MAXV) begin
                cnt_next = '0;
                cnt_wrap = 1'b1;
            end else begin
                cnt_next = bnat + 1'b1;
            end
        end else begin
            if (bnat == '0) begin
                cnt_next = MAXV;
                cnt_wrap = 1'b1;
            end else begin
                cnt_next = bnat - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bnat <= '0;
            pre  <= '0;
            step <= 1'b0;
            tc   <= 1'b0;
        end else if (load) begin
            // A load restarts the prescale period and always reports a change.
            bnat <= load_clamped;
            pre  <= '0;
            step <= 1'b1;
            tc   <= 1'b0;
        end else if (step_cyc) begin
            bnat <= cnt_next;
            pre  <= '0;
            step <= 1'b1;
            tc   <= cnt_wrap;
        end else begin
            if (en) begin
                pre <= pre + 1'b1;
            end
            step <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bnat_counter.sv
// Table-driven bench for bnat_counter with PRESCALE=1 and PRESCALE=3 instances.
module tb_bnat_counter;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic [3:0] eb;
        logic       es;
        logic       et;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1, en1 = 1'b0, up1 = 1'b1, load1 = 1'b0;
    logic [3:0] lv1 = 4'd0;
    logic [3:0] bnat1;
    logic       step1, tc1;
    logic       rst3 = 1'b1, en3 = 1'b0, up3 = 1'b1, load3 = 1'b0;
    logic [3:0] lv3 = 4'd0;
    logic [3:0] bnat3;
    logic       step3, tc3;

    int errors = 0;
    int checks = 0;

    vec_t t1[$];
    vec_t t3[$];

    always #5 clk = ~clk;

    bnat_counter #(.WIDTH(4), .MAX(8), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst1), .en(en1), .up(up1), .load(load1),
        .load_val(lv1), .bnat(bnat1), .step(step1), .tc(tc1)
    );

    bnat_counter #(.WIDTH(4), .MAX(8), .PRESCALE(3)) u_p3 (
        .clk(clk), .rst(rst3), .en(en3), .up(up3), .load(load3),
        .load_val(lv3), .bnat(bnat3), .step(step3), .tc(tc3)
    );

    function automatic vec_t mk(input logic r, input logic e, input logic u,
                                input logic l, input logic [3:0] v,
                                input logic [3:0] b, input logic s, input logic t);
        vec_t x;
        x.rst = r; x.en = e; x.up = u; x.load = l; x.lv = v;
        x.eb = b; x.es = s; x.et = t;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic run1(input vec_t v, input int idx);
        rst1 = v.rst; en1 = v.en; up1 = v.up; load1 = v.load; lv1 = v.lv;
        @(posedge clk);
        #1;
        chk("p1.bnat", idx, int'(bnat1), int'(v.eb));
        chk("p1.step", idx, int'(step1), int'(v.es));
        chk("p1.tc",   idx, int'(tc1),   int'(v.et));
    endtask

    task automatic run3(input vec_t v, input int idx);
        rst3 = v.rst; en3 = v.en; up3 = v.up; load3 = v.load; lv3 = v.lv;
        @(posedge clk);
        #1;
        chk("p3.bnat", idx, int'(bnat3), int'(v.eb));
        chk("p3.step", idx, int'(step3), int'(v.es));
        chk("p3.tc",   idx, int'(tc3),   int'(v.et));
    endtask

    initial begin
        // PRESCALE=1: reset with en/load active, up wrap, load, down wrap, turn-around, clamp.
        for (int i = 0; i < 3; i++) t1.push_back(mk(1, 1, 1, 1, 4'd5, 4'd0, 0, 0));
        for (int i = 1; i <= 8; i++) t1.push_back(mk(0, 1, 1, 0, 4'd0, 4'(i), 1, 0));
        t1.push_back(mk(0, 1, 1, 0, 4'd0, 4'd0, 1, 1));
        t1.push_back(mk(0, 1, 1, 0, 4'd0, 4'd1, 1, 0));
        t1.push_back(mk(0, 0, 1, 1, 4'd2, 4'd2, 1, 0));
        t1.push_back(mk(0, 1, 0, 0, 4'd0, 4'd1, 1, 0));
        t1.push_back(mk(0, 1, 0, 0, 4'd0, 4'd0, 1, 0));
        t1.push_back(mk(0, 1, 0, 0, 4'd0, 4'd8, 1, 1));
        t1.push_back(mk(0, 1, 0, 0, 4'd0, 4'd7, 1, 0));
        t1.push_back(mk(0, 1, 1, 0, 4'd0, 4'd8, 1, 0));
        t1.push_back(mk(0, 1, 1, 1, 4'd13, 4'd8, 1, 0));
        t1.push_back(mk(0, 0, 1, 0, 4'd0, 4'd8, 0, 0));
        t1.push_back(mk(0, 0, 1, 1, 4'd8, 4'd8, 1, 0));
        t1.push_back(mk(0, 1, 1, 0, 4'd0, 4'd0, 1, 1));

        // PRESCALE=3: step every third enabled cycle, en gaps, clamp, mid-prescale load and reset.
        t3.push_back(mk(1, 1, 1, 1, 4'd7, 4'd0, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd0, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd0, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd1, 1, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd1, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd1, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd2, 1, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd2, 0, 0));
        t3.push_back(mk(0, 0, 1, 0, 4'd0, 4'd2, 0, 0));
        t3.push_back(mk(0, 0, 1, 0, 4'd0, 4'd2, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd2, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd3, 1, 0));
        t3.push_back(mk(0, 1, 1, 1, 4'd13, 4'd8, 1, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd8, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd8, 0, 0));
        t3.push_back(mk(0, 1, 1, 1, 4'd5, 4'd5, 1, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd5, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd5, 0, 0));
        t3.push_back(mk(0, 1, 1, 0, 4'd0, 4'd6, 1, 0));
    end

    initial begin
        @(negedge clk);
        for (int i = 0; i < t1.size(); i++) run1(t1[i], i);
        rst1 = 1'b0; en1 = 1'b0; load1 = 1'b0;

        for (int i = 0; i < t3.size(); i++) run3(t3[i], i);
        // bnat=6 with prescaler at 1, then a one-cycle reset discards the partial count.
        run3(mk(0, 1, 1, 0, 4'd0, 4'd6, 0, 0), 100);
        run3(mk(1, 1, 1, 0, 4'd0, 4'd0, 0, 0), 101);
        run3(mk(0, 1, 1, 0, 4'd0, 4'd0, 0, 0), 102);
        run3(mk(0, 1, 1, 0, 4'd0, 4'd0, 0, 0), 103);
        run3(mk(0, 1, 1, 0, 4'd0, 4'd1, 1, 0), 104);
        // Up wrap with tc, then a direction change mid-prescale applies at the next step.
        run3(mk(0, 0, 1, 1, 4'd8, 4'd8, 1, 0), 110);
        run3(mk(0, 1, 1, 0, 4'd0, 4'd8, 0, 0), 111);
        run3(mk(0, 1, 1, 0, 4'd0, 4'd8, 0, 0), 112);
        run3(mk(0, 1, 1, 0, 4'd0, 4'd0, 1, 1), 113);
        run3(mk(0, 1, 1, 0, 4'd0, 4'd0, 0, 0), 114);
        run3(mk(0, 1, 0, 0, 4'd0, 4'd0, 0, 0), 115);
        run3(mk(0, 1, 0, 0, 4'd0, 4'd8, 1, 1), 116);
        run3(mk(0, 0, 0, 0, 4'd0, 4'd8, 0, 0), 117);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
